// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial comparator controller.
//   state_e : FSM state encoding (IDLE/SCAN/DONE)
//   res_e   : 2-bit result code (EQ/GT/LT) for consumers that want a packed verdict
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_GT = 2'd1,
        RES_LT = 2'd2
    } res_e;

endpackage

// File: rtl/comparator_1bit_struct.sv
// Single-bit magnitude comparator slice.
// Ports:
//   a, b : input bits
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
module comparator_1bit_struct (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);

    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_comparator_ctrl.sv
// Serial unsigned comparator: steps one 1-bit slice MSB-first across two
// WIDTH-bit operands, one bit per clock, with a start/busy/done handshake.
// Results are registered and held until the next comparison's DONE cycle.
//
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN: leave SCAN on the first
// differing bit instead of always scanning all WIDTH bits.
//
// Ports:
//   clk           : rising-edge clock
//   rst           : synchronous active-high reset
//   start         : request, sampled only in IDLE
//   a, b          : operands, latched when start is accepted
//   busy          : high in SCAN and DONE
//   done          : one-cycle pulse when results become valid
//   a_maior_que_b : registered A > B
//   a_menor_que_b : registered A < B
//   a_igual_b     : registered A == B
module serial_comparator_ctrl
    import serial_cmp_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_maior_que_b,
    output logic             a_menor_que_b,
    output logic             a_igual_b
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             res_gt_q, res_gt_d;
    logic             res_lt_q, res_lt_d;
    logic             res_eq_q, res_eq_d;

    logic slice_gt, slice_lt, slice_eq;
    logic first_diff;

    comparator_1bit_struct u_slice (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .gt (slice_gt),
        .lt (slice_lt),
        .eq (slice_eq)
    );

    // Only the most significant differing bit decides the verdict.
    assign first_diff = ~decided_q & ~slice_eq;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        res_gt_d  = res_gt_q;
        res_lt_d  = res_lt_q;
        res_eq_d  = res_eq_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    idx_d     = IDX_W'(WIDTH - 1);
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (first_diff) begin
                    decided_d = 1'b1;
                    gt_d      = slice_gt;
                    lt_d      = slice_lt;
                end
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (first_diff) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered: derive them from the next state so they
        // line up with the state they describe. Results load on entry to
        // DONE using the flags as updated by the final scanned bit.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            res_gt_d = gt_d;
            res_lt_d = lt_d;
            res_eq_d = ~(gt_d | lt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_gt_q  <= 1'b0;
            res_lt_q  <= 1'b0;
            res_eq_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_gt_q  <= res_gt_d;
            res_lt_q  <= res_lt_d;
            res_eq_q  <= res_eq_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign a_maior_que_b = res_gt_q;
    assign a_menor_que_b = res_lt_q;
    assign a_igual_b     = res_eq_q;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Directed bench for serial_comparator_ctrl: a WIDTH=8 instance driven from a
// vector table plus hand-written reset/held-start/back-to-back sequences, and
// a WIDTH=2 instance swept over all operand pairs.
module tb_serial_comparator_ctrl;
    import serial_cmp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, busy8, done8, gt8, lt8, eq8;
    logic [7:0] a8, b8;
    logic       start2, busy2, done2, gt2, lt2, eq2;
    logic [1:0] a2, b2;

    serial_comparator_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8),
        .a_maior_que_b(gt8), .a_menor_que_b(lt8), .a_igual_b(eq8)
    );

    serial_comparator_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2),
        .a_maior_que_b(gt2), .a_menor_que_b(lt2), .a_igual_b(eq2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        res_e       exp;
        int         fix_cyc;
        int         early_cyc;
    } vec_t;

    vec_t       vecs[10];
    int         total = 0;
    int         bad   = 0;
    logic [2:0] held8, held2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] bits_of(input res_e r);
        case (r)
            RES_GT:  return 3'b100;
            RES_LT:  return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done2 : done8;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy2 : busy8;
    endfunction

    function automatic logic [2:0] cur_bits(input bit sel);
        return sel ? {gt2, lt2, eq2} : {gt8, lt8, eq8};
    endfunction

    // Call immediately after the accepting clock edge. Follows the scan
    // cycle by cycle until done, then checks the following IDLE cycle.
    task automatic watch(input bit sel, input int exp_cyc, input logic [2:0] exp_bits,
                         input bit scramble, input string tag);
        bit         seen = 1'b0;
        int         cyc  = 0;
        logic [2:0] held;
        held = sel ? held2 : held8;
        while (!seen && cyc < 40) begin
            cyc++;
            #1;
            if (cyc == 1) begin
                if (!scramble) begin
                    if (sel) start2 = 1'b0;
                    else     start8 = 1'b0;
                end
                chk({tag, "_hold"}, 32'(cur_bits(sel)), 32'(held));
            end
            if (cur_done(sel)) begin
                seen = 1'b1;
                chk({tag, "_latency"}, cyc, exp_cyc);
                chk({tag, "_result"}, 32'(cur_bits(sel)), 32'(exp_bits));
                chk({tag, "_busy_at_done"}, 32'(cur_busy(sel)), 1);
            end else begin
                chk({tag, "_busy"}, 32'(cur_busy(sel)), 1);
                if (scramble) begin
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                end
                @(posedge clk);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done at cycle %0d", tag, exp_cyc);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(cur_done(sel)), 0);
        chk({tag, "_busy_idle"}, 32'(cur_busy(sel)), 0);
        chk({tag, "_result_held"}, 32'(cur_bits(sel)), 32'(exp_bits));
        if (sel) held2 = exp_bits;
        else     held8 = exp_bits;
    endtask

    initial begin
        int  exp_cyc;
        bit  saw_done;

        vecs[0] = '{8'hA5, 8'hA5, RES_EQ, 9, 9};
        vecs[1] = '{8'h80, 8'h7F, RES_GT, 9, 2};
        vecs[2] = '{8'h01, 8'h02, RES_LT, 9, 8};
        vecs[3] = '{8'hFF, 8'h00, RES_GT, 9, 2};
        vecs[4] = '{8'h00, 8'h00, RES_EQ, 9, 9};
        vecs[5] = '{8'h00, 8'h01, RES_LT, 9, 9};
        vecs[6] = '{8'h7F, 8'h80, RES_LT, 9, 2};
        vecs[7] = '{8'hC3, 8'hC1, RES_GT, 9, 8};
        vecs[8] = '{8'h10, 8'h20, RES_LT, 9, 4};
        vecs[9] = '{8'hFE, 8'hFF, RES_LT, 9, 9};

        rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_w8", 32'({busy8, done8, gt8, lt8, eq8}), 0);
        chk("reset_w2", 32'({busy2, done2, gt2, lt2, eq2}), 0);
        rst = 1'b0;
        held8 = 3'b000;
        held2 = 3'b000;

        for (int i = 0; i < 10; i++) begin
            a8 = vecs[i].a;
            b8 = vecs[i].b;
            start8 = 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            exp_cyc = vecs[i].early_cyc;
`else
            exp_cyc = vecs[i].fix_cyc;
`endif
            @(posedge clk);
            watch(1'b0, exp_cyc, bits_of(vecs[i].exp), 1'b0, $sformatf("vec%0d", i));
        end

        // Reset lands on the fourth edge after acceptance; operands differ
        // only at bit 0 so neither build can finish before the reset.
        a8 = 8'h3C; b8 = 8'h3D; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midscan_reset", 32'({busy8, done8, gt8, lt8, eq8}), 0);
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) saw_done = 1'b1;
        end
        chk("aborted_no_done", 32'(saw_done), 0);
        held8 = 3'b000;
        held2 = 3'b000;

        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exp_cyc = 4;
`else
        exp_cyc = 9;
`endif
        @(posedge clk);
        watch(1'b0, exp_cyc, 3'b010, 1'b0, "post_reset");

        // start stays high and operands churn during the scan; only the
        // accepted pair counts, then the held start is taken again in IDLE.
        a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exp_cyc = 3;
`else
        exp_cyc = 9;
`endif
        @(posedge clk);
        watch(1'b0, exp_cyc, 3'b010, 1'b1, "held_start");
        a8 = 8'h05; b8 = 8'h05;
        @(posedge clk);
        watch(1'b0, 9, 3'b001, 1'b0, "back_to_back");

        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                a2 = 2'(ia);
                b2 = 2'(ib);
                start2 = 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                exp_cyc = ((ia >> 1) != (ib >> 1)) ? 2 : 3;
`else
                exp_cyc = 3;
`endif
                @(posedge clk);
                watch(1'b1, exp_cyc,
                      (ia > ib) ? 3'b100 : (ia < ib) ? 3'b010 : 3'b001,
                      1'b0, $sformatf("w2_a%0d_b%0d", ia, ib));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
